// File: rtl/sram_sdi_responder.sv
// Serial SRAM responder (23LC1024 style): oversamples sck/cs_n/d_in on the fabric clock,
// decodes SPI/SDI commands and serves an internal byte array.
module sram_sdi_responder #(
  parameter int ADDR_W      = 17,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       cs_n,
  input  logic [1:0] d_in,
  output logic [1:0] d_out,
  output logic [1:0] d_oe,
  output logic       mode_sdi,
  output logic [7:0] mode_reg
);
  typedef enum logic [3:0] {
    IDLE, CMD, ADDR, DUMMY, WDATA, RDATA, WRMR, RDMR, IGNORE
  } state_t;

  localparam int SW = 4 * SYNC_STAGES;

  // One shift chain carries {cs_n, sck, d_in[1:0]} through all synchronizer stages.
  logic [SW-1:0] sync_q;
  logic [SW+3:0] sync_d;
  logic          cs_s, sck_s;
  logic [1:0]    d_s;

  assign sync_d = {sync_q, cs_n, sck, d_in};
  assign {cs_s, sck_s, d_s} = sync_d[SW+3 -: 4];

  always_ff @(posedge clk) begin
    if (reset) sync_q <= {SYNC_STAGES{4'b1000}};
    else       sync_q <= sync_d[SW-1:0];
  end

  logic sck_prev_q;
  logic rise, fall;
  assign rise = sck_s & ~sck_prev_q;
  assign fall = ~sck_s & sck_prev_q;

  always_ff @(posedge clk) begin
    if (reset) sck_prev_q <= 1'b0;
    else       sck_prev_q <= sck_s;
  end

  state_t            state_q;
  logic [4:0]        cnt_q;
  logic [23:0]       sh_q;
  logic              is_write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        tx_q;
  logic [2:0]        ocnt_q;
  logic [1:0]        d_out_q, d_oe_q;
  logic              mode_sdi_q;
  logic [7:0]        mode_reg_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic [7:0]        rd_data_q;

  logic [4:0]  step;
  logic [4:0]  cnt_next;
  logic [23:0] sh_next;
  logic [3:0]  ocnt_sum;
  logic [1:0]  oe_val;
  logic [7:0]  cur;
  logic        unused_bits;

  assign step     = mode_sdi_q ? 5'd2 : 5'd1;
  assign cnt_next = cnt_q + step;
  assign sh_next  = mode_sdi_q ? {sh_q[21:0], d_s} : {sh_q[22:0], d_s[0]};
  assign ocnt_sum = {1'b0, ocnt_q} + (mode_sdi_q ? 4'd2 : 4'd1);
  assign oe_val   = mode_sdi_q ? 2'b11 : 2'b10;
  // A new byte is taken from its source only at the first bit; later bits come from tx_q.
  assign cur      = (ocnt_q != 3'd0) ? tx_q : ((state_q == RDMR) ? mode_reg_q : rd_data_q);
  assign unused_bits = sh_q[23];

  function automatic logic [ADDR_W-1:0] addr_adv(input logic [ADDR_W-1:0] a,
                                                 input logic [1:0] m);
    case (m)
      2'b00:   addr_adv = a;
      2'b10:   addr_adv = {a[ADDR_W-1:5], a[4:0] + 5'd1};
      default: addr_adv = a + 1'b1;
    endcase
  endfunction

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (wr_en_q) mem[wr_addr_q] <= wr_data_q;
    rd_data_q <= mem[addr_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      sh_q       <= 24'd0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      tx_q       <= 8'd0;
      ocnt_q     <= 3'd0;
      d_out_q    <= 2'b00;
      d_oe_q     <= 2'b00;
      mode_sdi_q <= 1'b0;
      mode_reg_q <= 8'h40;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'd0;
    end else begin
      wr_en_q <= 1'b0;
      if (cs_s) begin
        // Deselect aborts everything and takes priority over any coincident sck edge.
        state_q <= IDLE;
        d_oe_q  <= 2'b00;
        cnt_q   <= 5'd0;
        ocnt_q  <= 3'd0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= CMD;
            cnt_q   <= 5'd0;
            ocnt_q  <= 3'd0;
          end
          CMD: if (rise) begin
            sh_q  <= sh_next;
            cnt_q <= cnt_next;
            if (cnt_next == 5'd8) begin
              cnt_q <= 5'd0;
              case (sh_next[7:0])
                8'h03: begin is_write_q <= 1'b0; state_q <= ADDR; end
                8'h02: begin is_write_q <= 1'b1; state_q <= ADDR; end
                8'h01: state_q <= WRMR;
                8'h05: begin state_q <= RDMR; d_oe_q <= oe_val; end
                8'h3B: begin mode_sdi_q <= 1'b1; state_q <= IGNORE; end
                8'hFF: begin mode_sdi_q <= 1'b0; state_q <= IGNORE; end
                default: state_q <= IGNORE;
              endcase
            end
          end
          ADDR: if (rise) begin
            sh_q  <= sh_next;
            cnt_q <= cnt_next;
            if (cnt_next == 5'd24) begin
              cnt_q  <= 5'd0;
              addr_q <= sh_next[ADDR_W-1:0];
              if (is_write_q)      state_q <= WDATA;
              else if (mode_sdi_q) state_q <= DUMMY;
              else begin
                state_q <= RDATA;
                d_oe_q  <= oe_val;
              end
            end
          end
          DUMMY: if (rise) begin
            cnt_q <= cnt_next;
            if (cnt_next == 5'd8) begin
              cnt_q   <= 5'd0;
              state_q <= RDATA;
              d_oe_q  <= oe_val;
            end
          end
          WDATA: if (rise) begin
            sh_q  <= sh_next;
            cnt_q <= cnt_next;
            if (cnt_next == 5'd8) begin
              cnt_q     <= 5'd0;
              wr_en_q   <= 1'b1;
              wr_addr_q <= addr_q;
              wr_data_q <= sh_next[7:0];
              addr_q    <= addr_adv(addr_q, mode_reg_q[7:6]);
            end
          end
          WRMR: if (rise) begin
            sh_q  <= sh_next;
            cnt_q <= cnt_next;
            if (cnt_next == 5'd8) begin
              cnt_q      <= 5'd0;
              mode_reg_q <= sh_next[7:0];
              state_q    <= IGNORE;
            end
          end
          RDATA, RDMR: if (fall) begin
            d_out_q <= mode_sdi_q ? cur[7:6] : {cur[7], 1'b0};
            tx_q    <= mode_sdi_q ? {cur[5:0], 2'b00} : {cur[6:0], 1'b0};
            ocnt_q  <= ocnt_sum[2:0];
            // Advancing after the last bit lets the BRAM fetch the next byte in time.
            if (ocnt_sum == 4'd8 && state_q == RDATA)
              addr_q <= addr_adv(addr_q, mode_reg_q[7:6]);
          end
          IGNORE: ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign d_out    = d_out_q;
  assign d_oe     = d_oe_q;
  assign mode_sdi = mode_sdi_q;
  assign mode_reg = mode_reg_q;
endmodule

// File: doc/sram_sdi_responder.md
Name: sram_sdi_responder

Overview:
- Synthesizable model of a 23LC1024-style serial SRAM: the responder end of the SPI/SDI SRAM bus that our SDI test master drives.
- Runs on the fabric clock and oversamples sck, cs_n and d.
- Decodes READ, WRITE, RDMR, WRMR, EDIO and RSTIO and serves an internal byte array.
- Used as an on-board loopback target and as the memory model in simulation benches for SRAM masters.

Parameters:
- ADDR_W, 17: implemented address bits; memory is 2^ADDR_W bytes, upper address bits ignored (aliasing).
- SYNC_STAGES, 2: synchronizer depth on sck, cs_n and d_in.

Ports:
- clk  in  1  fabric clock; sck high and low phases each >= SYNC_STAGES+2 clk.
- reset  in  1  synchronous, active-high.
- sck  in  1  serial clock from the master; idles low (mode 0).
- cs_n  in  1  chip select, active low.
- d_in  in  2  pad inputs: SPI uses d_in[0] as SI; SDI uses both, d_in[1] = MSB of the pair.
- d_out  out  2  pad output data.
- d_oe  out  2  per-bit output enable for the top-level tristate.
- mode_sdi  out  1  1 = dual (SDI) I/O mode active.
- mode_reg  out  8  current mode register.

Behaviour:
- Reset: d_out=0, d_oe=0, mode_sdi=0, mode_reg=8'h40 (sequential), FSM=IDLE. Memory contents are not cleared.
- Input sampling and edges:
  - All inputs pass through SYNC_STAGES flops.
  - Rising sck edge: a 1-clk pulse detected on the synchronized sck.
  - Falling sck edge: likewise.
  - Input data is sampled on the rising-edge pulse.
  - Output data changes on the falling-edge pulse.
- Bits per sck:
  - SPI: 1 bit, MSB first, on d_in[0].
  - SDI: 2 bits, {d_in[1], d_in[0]}, MSB pair first.
  - A byte is therefore 8 sck (SPI) or 4 sck (SDI).
- FSM states: IDLE, CMD, ADDR, DUMMY, WDATA, RDATA, WRMR, RDMR, IGNORE.
- Transitions:
  - IDLE -> CMD on synchronized cs_n low.
  - CMD: shift 8 bits, then decode:
    - 0x03 -> ADDR (read).
    - 0x02 -> ADDR (write).
    - 0x01 -> WRMR.
    - 0x05 -> RDMR.
    - 0x3B -> set mode_sdi=1, go to IGNORE.
    - 0xFF -> set mode_sdi=0, go to IGNORE.
    - Any other code -> IGNORE.
  - ADDR: 24 bits. On completion, write goes to WDATA. Read goes to DUMMY if mode_sdi=1, otherwise directly to RDATA.
  - DUMMY: 8 bits ignored (4 sck), then RDATA.
  - WRMR: 8 bits loaded into mode_reg on byte completion; further bits ignored.
  - RDMR: shifts out mode_reg, repeating while cs_n stays low.
- Write path:
  - Each completed byte is committed to mem[addr] on the clk after its last rising edge.
  - Address then advances.
  - A partial byte at cs_n rise is discarded.
- Read path:
  - The byte at addr is fetched as ADDR/DUMMY completes.
  - The first bit/pair is driven on the falling edge following the last address/dummy rising edge.
  - The next byte is fetched after the last bit of the current byte is driven.
- Address advance, by mode_reg[7:6]:
  - 00 byte: address held.
  - 10 page: addr[4:0] increments, wrapping within the 32-byte page.
  - 01 sequential: addr[ADDR_W-1:0] increments, wrapping 2^ADDR_W-1 -> 0.
  - 11: treated as sequential.
- Output enables:
  - SPI: d_oe=2'b10 during RDATA/RDMR; data on d_out[1].
  - SDI: d_oe=2'b11 during RDATA/RDMR.
  - d_oe=0 in every other state.
- cs_n rising (synchronized) in any state:
  - FSM -> IDLE and d_oe=0 on the same clk.
  - Shift counters cleared; mode_sdi and mode_reg kept.
  - This is the only abort mechanism.
- reset asserted mid-transaction: immediate return to reset values; memory unchanged.
- sck edges while cs_n high are ignored.
- Simultaneous cs_n rise and sck edge: cs_n wins and the edge is ignored.

Test Plan:
- After reset, SPI RDMR (cs_n low, 0x05, 16 sck) -> d_oe=2'b10, first 8 bits out = 0x40, mode_sdi=0.
- SPI 0x3B -> mode_sdi=1. SDI write 0x02, addr 0x000000, data A5 5A 00 FF, cs_n high. SDI read 0x03, addr 0x000000, 4-sck dummy -> d_out pairs give A5 5A 00 FF, d_oe=2'b11 only in RDATA.
- WRMR 0x80 (page mode), write at 0x00001E bytes 11 22 33 -> mem[1E]=11, mem[1F]=22, mem[00]=33; mem[20] unchanged.
- Sequential mode: write at 0x01FFFF bytes 77 88 (ADDR_W=17) -> mem[1FFFF]=77, mem[00000]=88.
- cs_n raised after 2 sck of a data byte during write -> no memory change, d_oe=0 on the same clk as synchronized cs_n high, next transaction decodes normally.
- Unknown command 0x9F in SPI -> d_oe stays 0 for 32 sck. Then 0xFF in SDI mode -> mode_sdi=0, and a subsequent SPI read returns correct data on d_out[1].
